load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core's memory stage and `memory_map`. It turns byte, halfword and word loads and stores into the word-only, combinational-read and synchronous-write port of `memory_map`. Sub-word stores use a read-modify-write sequence. Accesses complete through a valid/ready request and a single-cycle response strobe.

## Interface
Parameters:
- none (address/data widths come from `addr_t`/`data_t`, 32 bits)

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `req_valid`  in  1  core presents an access
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  zero-extend loads (LBU/LHU)
- `req_addr`  in  `addr_t`  byte address
- `req_wdata`  in  `data_t`  store data, right-aligned
- `resp_valid`  out  1  one-cycle completion strobe
- `resp_rdata`  out  `data_t`  load result, extended; 0 for stores and errors
- `resp_error`  out  1  misaligned or illegal access, valid with `resp_valid`
- `mem_address`  out  `addr_t`  to `memory_map.address`
- `mem_write_data`  out  `data_t`  to `memory_map.write_data`
- `mem_write_enable`  out  1  to `memory_map.write_enable`
- `mem_read_data`  in  `data_t`  from `memory_map.read_data`, combinational on `mem_address`

## Operation
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register addr, size, unsigned, write and wdata.
  - Next state:
    - error → RESP
    - load → LOAD
    - word store → WRITE
    - sub-word store → RMW_READ
- LOAD:
  - `mem_address` = {addr[31:2],2'b00}.
  - Select the lane by addr[1:0] (half lane by addr[1]), then sign- or zero-extend.
  - Register into `resp_rdata`; → RESP.
- RMW_READ:
  - Same address; register `mem_read_data` as the old word.
  - → WRITE.
- WRITE:
  - `mem_write_enable`=1.
  - `mem_write_data`:
    - word store: wdata
    - sub-word store: old word with the byte/half lane replaced by wdata[7:0] or wdata[15:0]
  - → RESP.
- RESP: `resp_valid`=1 for exactly one cycle; → IDLE. `req_ready`=0.
- Error conditions:
  - `req_size`=11.
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
  - Response: no memory cycle is issued; `resp_error`=1, `resp_rdata`=0.
- Side-effect safety:
  - `memory_map` latches its LED register whenever `mem_address` matches, regardless of write enable.
  - Therefore, in every state except WRITE, `mem_write_data` = `mem_read_data` (idempotent write-back).
  - In IDLE and RESP, `mem_address`=0.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=1.
  - `resp_valid`=0, `resp_rdata`=0, `resp_error`=0.
  - `mem_address`=0, `mem_write_enable`=0.
- Latency from acceptance edge (cycle 0) to the `resp_valid` cycle:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
- The memory write commits at the rising edge that ends WRITE.
- A new request can be accepted in the cycle after RESP (IDLE); there is no back-to-back overlap.
- `mem_*` outputs are decoded combinationally from state and registered fields. `mem_write_enable` never glitches high outside WRITE.
- Reset asserted mid-access: immediate return to IDLE, `mem_write_enable` drops asynchronously, and no response is produced.
  - An aborted RMW leaves memory unchanged.
  - An abort during WRITE at the same edge is undefined and not tested.
- `req_*` is sampled only on the acceptance edge; later changes are ignored.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: misaligned half/word accesses flag `resp_error` as above.
- Not defined:
  - Misaligned accesses are force-aligned (half clears addr[0], word clears addr[1:0]) and complete normally with `resp_error`=0.
  - `req_size`=11 still errors.

## Structure
- The shared package holds:
  - `lsu_size_t` enum (`LSU_BYTE`, `LSU_HALF`, `LSU_WORD`)
  - `lsu_state_t` enum
- Existing `addr_t`/`data_t` are reused.
- One sub-module, `lsu_lane`, is combinational:
  - extract and extend for loads
  - lane merge for stores
  - It is shared by LOAD and WRITE.

## Test plan
- Word store 0xDEADBEEF @0x40, then word load @0x40 → `resp_rdata`=0xDEADBEEF; store and load each `resp_valid` at +2 cycles.
- With 0x40=0xDEADBEEF, byte store 0x11 @0x42 → word reads 0xDE11BEEF. Signed byte load @0x43 → 0xFFFFFFDE. `req_unsigned` byte load @0x43 → 0x000000DE.
- Half load @0x42 of 0x8001xxxx → 0xFFFF8001 signed, 0x00008001 unsigned; half store completes at +3 cycles.
- Word load @0x41:
  - with `LSU_MISALIGN_CHECK_EN`: `resp_error`=1, `resp_rdata`=0 at +1, and `mem_write_enable` never asserts.
  - without it: returns the word @0x40.
- Byte store 0x3 @0x10000000 → the LED register reads 0x3; during IDLE and RMW_READ the LED value is unchanged.
- Assert `rst_n` low during RMW_READ → IDLE, no `resp_valid`, target word unchanged.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: bus widths, access sizes and FSM states.
// Optional feature macro used by this slice: LSU_MISALIGN_CHECK_EN.
package load_store_unit_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } lsu_state_t;

    // Drop the low address bits a naturally aligned access of this size cannot use.
    function automatic addr_t align_addr(input addr_t addr, input logic [1:0] size);
        addr_t aligned;
        aligned = addr;
        if (size == LSU_HALF) begin
            aligned[0] = 1'b0;
        end else if (size == LSU_WORD) begin
            aligned[1:0] = 2'b00;
        end
        return aligned;
    endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Byte/half lane logic: extracts and extends load data, merges store data into an old word.
// Behaviour does not depend on LSU_MISALIGN_CHECK_EN; the caller supplies a usable offset.
module lsu_lane
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  lsu_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [4:0]  bit_pos;

    assign bit_pos   = {offset, 3'b000};
    assign byte_lane = word[bit_pos +: 8];
    assign half_lane = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = word;
        case (size)
            LSU_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            LSU_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default:  load_data = word;
        endcase
    end

    always_comb begin
        merge_data = word;
        case (size)
            LSU_BYTE: merge_data[bit_pos +: 8] = wdata[7:0];
            LSU_HALF: begin
                if (offset[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0] = wdata[15:0];
                end
            end
            default:  merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit adapting byte/half/word accesses onto a word-only memory port.
// Define LSU_MISALIGN_CHECK_EN to report misaligned accesses; otherwise they are force-aligned.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    lsu_state_t state, next_state;

    addr_t     addr_q;
    lsu_size_t size_q;
    logic      unsigned_q;
    logic      write_q;
    data_t     wdata_q;
    data_t     old_q;
    logic      error_q;
    data_t     rdata_q;

    logic      req_error;
    logic      misaligned;
    addr_t     accept_addr;
    data_t     lane_word;
    data_t     load_data;
    data_t     merge_data;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned  = ((req_size == LSU_HALF) && req_addr[0]) ||
                         ((req_size == LSU_WORD) && (req_addr[1:0] != 2'b00));
    assign accept_addr = req_addr;
`else
    assign misaligned  = 1'b0;
    assign accept_addr = align_addr(req_addr, req_size);
`endif

    assign req_error = (req_size == 2'b11) || misaligned;

    // The lane sees the live memory word when loading and the saved old word when merging.
    assign lane_word = (state == WRITE) ? old_q : mem_read_data;

    lsu_lane u_lane (
        .word        (lane_word),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_error) begin
                        next_state = RESP;
                    end else if (!req_write) begin
                        next_state = LOAD;
                    end else if (req_size == LSU_WORD) begin
                        next_state = WRITE;
                    end else begin
                        next_state = RMW_READ;
                    end
                end
            end
            LOAD:     next_state = RESP;
            RMW_READ: next_state = WRITE;
            WRITE:    next_state = RESP;
            RESP:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            size_q     <= LSU_BYTE;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            old_q      <= '0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= accept_addr;
                        size_q     <= lsu_size_t'(req_size);
                        unsigned_q <= req_unsigned;
                        write_q    <= req_write;
                        wdata_q    <= req_wdata;
                        error_q    <= req_error;
                        rdata_q    <= '0;
                    end
                end
                LOAD:     rdata_q <= load_data;
                RMW_READ: old_q   <= mem_read_data;
                default: ;
            endcase
        end
    end

    // Outside WRITE the memory sees its own read data, so address-triggered registers stay put.
    always_comb begin
        req_ready        = (state == IDLE);
        resp_valid       = (state == RESP);
        resp_error       = (state == RESP) && error_q;
        resp_rdata       = rdata_q;
        mem_address      = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = mem_read_data;
        case (state)
            LOAD, RMW_READ: mem_address = {addr_q[31:2], 2'b00};
            WRITE: begin
                mem_address      = {addr_q[31:2], 2'b00};
                mem_write_enable = write_q;
                mem_write_data   = merge_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural memory_map (word RAM plus LED register).
module tb_load_store_unit;

    localparam logic [31:0] LED_ADDR = 32'h1000_0000;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
        logic        we;
    } resp_t;

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        resp_t       exp;
    } acc_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    bit [31:0] mem [0:255];
    bit [31:0] led;

    resp_t sb [$];
    int compared = 0;
    int mismatched = 0;

    load_store_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory_map: combinational read, synchronous write, LED latches on address match.
    always_comb begin
        mem_read_data = 32'h0;
        if (mem_address == LED_ADDR) begin
            mem_read_data = led;
        end else if (mem_address < 32'h400) begin
            mem_read_data = mem[mem_address[9:2]];
        end
    end

    always @(posedge clk) begin
        if (mem_write_enable && (mem_address < 32'h400)) begin
            mem[mem_address[9:2]] <= mem_write_data;
        end
        if (mem_address == LED_ADDR) begin
            led <= mem_write_data;
        end
    end

    function automatic acc_t mk(input string n, input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                input logic err, input int lat, input logic we);
        acc_t t;
        t.name = n;
        t.w = w;
        t.sz = sz;
        t.u = u;
        t.a = a;
        t.wd = wd;
        t.exp.rdata = rd;
        t.exp.err = err;
        t.exp.lat = 8'(lat);
        t.exp.we = we;
        return t;
    endfunction

    // Drives one request, pushes its expected response, and collects what the DUT returned.
    task automatic access(input acc_t t, output resp_t obs);
        sb.push_back(t.exp);
        obs = '0;
        obs.lat = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        req_valid    = 1'b1;
        req_write    = t.w;
        req_size     = t.sz;
        req_unsigned = t.u;
        req_addr     = t.a;
        req_wdata    = t.wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_write    = ~t.w;
        req_size     = 2'b11;
        req_unsigned = ~t.u;
        req_addr     = ~t.a;
        req_wdata    = ~t.wd;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mem_write_enable) obs.we = 1'b1;
            if (resp_valid) begin
                obs.lat   = 8'(i);
                obs.rdata = resp_rdata;
                obs.err   = resp_error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        compared++; if (resp_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        compared++; if (resp_error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_resp_error: got %b expected 0", resp_error); end
        compared++; if (mem_address !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_address: got %h expected 0", mem_address); end
        compared++; if (mem_write_enable !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_write_enable); end
    endtask

    task automatic test_word();
        acc_t tbl [$];
        resp_t obs, e;
        tbl.push_back(mk("sw_40", 1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 2, 1));
        tbl.push_back(mk("lw_40", 0, 2'b10, 0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, 2, 0));
        foreach (tbl[i]) begin
            access(tbl[i], obs);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL %s: got rdata=%h err=%b lat=%0d we=%b expected rdata=%h err=%b lat=%0d we=%b",
                         tbl[i].name, obs.rdata, obs.err, obs.lat, obs.we, e.rdata, e.err, e.lat, e.we);
            end
        end
    endtask

    task automatic test_byte();
        acc_t tbl [$];
        resp_t obs, e;
        tbl.push_back(mk("sb_42",  1, 2'b00, 0, 32'h42, 32'h0000_0011, 32'h0, 0, 3, 1));
        tbl.push_back(mk("lw_40b", 0, 2'b10, 0, 32'h40, 32'h0, 32'hDE11_BEEF, 0, 2, 0));
        tbl.push_back(mk("lb_43",  0, 2'b00, 0, 32'h43, 32'h0, 32'hFFFF_FFDE, 0, 2, 0));
        tbl.push_back(mk("lbu_43", 0, 2'b00, 1, 32'h43, 32'h0, 32'h0000_00DE, 0, 2, 0));
        tbl.push_back(mk("lb_40",  0, 2'b00, 0, 32'h40, 32'h0, 32'hFFFF_FFEF, 0, 2, 0));
        tbl.push_back(mk("lbu_41", 0, 2'b00, 1, 32'h41, 32'h0, 32'h0000_00BE, 0, 2, 0));
        foreach (tbl[i]) begin
            access(tbl[i], obs);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL %s: got rdata=%h err=%b lat=%0d we=%b expected rdata=%h err=%b lat=%0d we=%b",
                         tbl[i].name, obs.rdata, obs.err, obs.lat, obs.we, e.rdata, e.err, e.lat, e.we);
            end
        end
    endtask

    task automatic test_half();
        acc_t tbl [$];
        resp_t obs, e;
        tbl.push_back(mk("sw_44",  1, 2'b10, 0, 32'h44, 32'h8001_5678, 32'h0, 0, 2, 1));
        tbl.push_back(mk("lh_46",  0, 2'b01, 0, 32'h46, 32'h0, 32'hFFFF_8001, 0, 2, 0));
        tbl.push_back(mk("lhu_46", 0, 2'b01, 1, 32'h46, 32'h0, 32'h0000_8001, 0, 2, 0));
        tbl.push_back(mk("lh_44",  0, 2'b01, 0, 32'h44, 32'h0, 32'h0000_5678, 0, 2, 0));
        tbl.push_back(mk("sh_44",  1, 2'b01, 0, 32'h44, 32'h1234_ABCD, 32'h0, 0, 3, 1));
        tbl.push_back(mk("lw_44",  0, 2'b10, 0, 32'h44, 32'h0, 32'h8001_ABCD, 0, 2, 0));
        foreach (tbl[i]) begin
            access(tbl[i], obs);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL %s: got rdata=%h err=%b lat=%0d we=%b expected rdata=%h err=%b lat=%0d we=%b",
                         tbl[i].name, obs.rdata, obs.err, obs.lat, obs.we, e.rdata, e.err, e.lat, e.we);
            end
        end
    endtask

    task automatic test_misalign();
        acc_t tbl [$];
        resp_t obs, e;
`ifdef LSU_MISALIGN_CHECK_EN
        tbl.push_back(mk("lw_41", 0, 2'b10, 0, 32'h41, 32'h0, 32'h0, 1, 1, 0));
        tbl.push_back(mk("lh_43", 0, 2'b01, 0, 32'h43, 32'h0, 32'h0, 1, 1, 0));
        tbl.push_back(mk("sw_42", 1, 2'b10, 0, 32'h42, 32'h5555_5555, 32'h0, 1, 1, 0));
`else
        tbl.push_back(mk("lw_41", 0, 2'b10, 0, 32'h41, 32'h0, 32'hDE11_BEEF, 0, 2, 0));
        tbl.push_back(mk("lh_43", 0, 2'b01, 0, 32'h43, 32'h0, 32'hFFFF_DE11, 0, 2, 0));
        tbl.push_back(mk("lhu_41", 0, 2'b01, 1, 32'h41, 32'h0, 32'h0000_BEEF, 0, 2, 0));
`endif
        tbl.push_back(mk("ill_ld", 0, 2'b11, 0, 32'h40, 32'h0, 32'h0, 1, 1, 0));
        tbl.push_back(mk("ill_st", 1, 2'b11, 0, 32'h40, 32'h7777_7777, 32'h0, 1, 1, 0));
        tbl.push_back(mk("lw_40c", 0, 2'b10, 0, 32'h40, 32'h0, 32'hDE11_BEEF, 0, 2, 0));
        foreach (tbl[i]) begin
            access(tbl[i], obs);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL %s: got rdata=%h err=%b lat=%0d we=%b expected rdata=%h err=%b lat=%0d we=%b",
                         tbl[i].name, obs.rdata, obs.err, obs.lat, obs.we, e.rdata, e.err, e.lat, e.we);
            end
        end
    endtask

    task automatic test_led();
        acc_t t;
        resp_t obs, e;
        logic saw_resp;
        t = mk("sw_led", 1, 2'b10, 0, LED_ADDR, 32'h0000_00F0, 32'h0, 0, 2, 1);
        access(t, obs);
        e = sb.pop_front();
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("[TB] FAIL sw_led: got rdata=%h err=%b lat=%0d we=%b expected rdata=%h err=%b lat=%0d we=%b",
                     obs.rdata, obs.err, obs.lat, obs.we, e.rdata, e.err, e.lat, e.we);
        end
        compared++; if (led !== 32'h0000_00F0) begin mismatched++; $display("[TB] FAIL led_preload: got %h expected 000000f0", led); end
        sb.push_back(resp_t'{rdata: 32'h0, err: 1'b0, lat: 8'd3, we: 1'b1});
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = LED_ADDR; req_wdata = 32'h0000_0003;
        compared++; if (led !== 32'h0000_00F0) begin mismatched++; $display("[TB] FAIL led_idle: got %h expected 000000f0", led); end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk);
        @(posedge clk);
        #1;
        compared++; if (led !== 32'h0000_00F0) begin mismatched++; $display("[TB] FAIL led_rmw_read: got %h expected 000000f0", led); end
        saw_resp = 1'b0;
        obs = '0;
        obs.lat = 8'hFF;
        obs.we = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (mem_write_enable) obs.we = 1'b1;
            if (resp_valid && !saw_resp) begin
                saw_resp = 1'b1;
                obs.lat = 8'(i);
                obs.rdata = resp_rdata;
                obs.err = resp_error;
                break;
            end
        end
        e = sb.pop_front();
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("[TB] FAIL sb_led: got rdata=%h err=%b lat=%0d we=%b expected rdata=%h err=%b lat=%0d we=%b",
                     obs.rdata, obs.err, obs.lat, obs.we, e.rdata, e.err, e.lat, e.we);
        end
        compared++; if (led !== 32'h0000_0003) begin mismatched++; $display("[TB] FAIL led_final: got %h expected 00000003", led); end
        @(negedge clk);
        @(negedge clk);
        compared++; if (led !== 32'h0000_0003) begin mismatched++; $display("[TB] FAIL led_after_idle: got %h expected 00000003", led); end
    endtask

    task automatic test_abort();
        logic saw_resp;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_ready: got %b expected 1", req_ready); end
        compared++; if (mem_write_enable !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_we: got %b expected 0", mem_write_enable); end
        compared++; if (mem_address !== 32'h0) begin mismatched++; $display("[TB] FAIL abort_addr: got %h expected 0", mem_address); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid || mem_write_enable) saw_resp = 1'b1;
        end
        compared++; if (saw_resp !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_no_resp: got activity=%b expected 0", saw_resp); end
        compared++; if (mem[16] !== 32'hDE11_BEEF) begin mismatched++; $display("[TB] FAIL abort_mem: got %h expected de11beef", mem[16]); end
    endtask

    task automatic test_back_to_back();
        acc_t tbl [$];
        resp_t obs, e;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            tbl.push_back(mk($sformatf("sw_r%0d", i), 1, 2'b10, 0, 32'h100 + 32'(i * 4), d, 32'h0, 0, 2, 1));
            tbl.push_back(mk($sformatf("lw_r%0d", i), 0, 2'b10, 0, 32'h100 + 32'(i * 4), 32'h0, d, 0, 2, 0));
            tbl.push_back(mk($sformatf("lbu_r%0d", i), 0, 2'b00, 1, 32'h101 + 32'(i * 4), 32'h0,
                             {24'h0, d[15:8]}, 0, 2, 0));
        end
        foreach (tbl[i]) begin
            access(tbl[i], obs);
            e = sb.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL %s: got rdata=%h err=%b lat=%0d we=%b expected rdata=%h err=%b lat=%0d we=%b",
                         tbl[i].name, obs.rdata, obs.err, obs.lat, obs.we, e.rdata, e.err, e.lat, e.we);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_led();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
